// File: rtl/apb4_to_reg_bridge_pkg.sv
// Shared types for the APB4-to-REG_BUS bridge.
//   state_e : bridge FSM states (IDLE, REQ, RESP)
//   req_t   : one captured register-bus request at the default bus widths
//             (addr, write, wdata, wstrb)
package apb4_to_reg_pkg;

  localparam int unsigned ReqAddrWidth = 32;
  localparam int unsigned ReqDataWidth = 32;
  localparam int unsigned ReqStrbWidth = ReqDataWidth / 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_e;

  typedef struct packed {
    logic [ReqAddrWidth-1:0] addr;
    logic                    write;
    logic [ReqDataWidth-1:0] wdata;
    logic [ReqStrbWidth-1:0] wstrb;
  } req_t;

endpackage

// File: rtl/apb4_to_reg_bridge_if.sv
// REG_BUS: simple valid/ready register bus.
//   out modport (master): drives addr, write, wdata, wstrb, valid;
//                         receives ready, rdata, error
//   in  modport (target): the mirror image
interface REG_BUS #(
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned DataWidth = 32
);

  logic [AddrWidth-1:0]   addr;
  logic                   write;
  logic [DataWidth-1:0]   wdata;
  logic [DataWidth/8-1:0] wstrb;
  logic                   valid;
  logic                   ready;
  logic [DataWidth-1:0]   rdata;
  logic                   error;

  modport out (
    output addr, write, wdata, wstrb, valid,
    input  ready, rdata, error
  );

  modport in (
    input  addr, write, wdata, wstrb, valid,
    output ready, rdata, error
  );

endinterface

// File: rtl/apb4_to_reg_bridge.sv
// apb4_to_reg_bridge: registered APB4 slave that forwards each access to a
// REG_BUS target and stretches the APB access phase until the target answers.
//
// Ports
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   psel_i, penable_i    APB select / access phase
//   pwrite_i, paddr_i    APB direction and address
//   pwdata_i, pstrb_i    APB write data and byte strobes
//   prdata_o, pready_o,  APB response (registered data/error, one-cycle ready)
//   pslverr_o
//   reg_o                REG_BUS master port
//
// Optional feature: define APB4_TO_REG_TIMEOUT_EN to abort an access that the
// target has not acknowledged within TimeoutCycles REQ cycles (error response,
// zero read data). Without the macro no counter exists and REQ waits forever.
module apb4_to_reg_bridge
  import apb4_to_reg_pkg::*;
#(
  parameter int unsigned DataWidth     = 32,
  parameter int unsigned AddrWidth     = 32,
  parameter int unsigned TimeoutCycles = 255
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   psel_i,
  input  logic                   penable_i,
  input  logic                   pwrite_i,
  input  logic [AddrWidth-1:0]   paddr_i,
  input  logic [DataWidth-1:0]   pwdata_i,
  input  logic [DataWidth/8-1:0] pstrb_i,
  output logic [DataWidth-1:0]   prdata_o,
  output logic                   pready_o,
  output logic                   pslverr_o,
  REG_BUS.out                    reg_o
);

  localparam int unsigned StrbWidth = DataWidth / 8;

  state_e                 state_q, state_d;
  logic [AddrWidth-1:0]   addr_q;
  logic                   write_q;
  logic [DataWidth-1:0]   wdata_q;
  logic [StrbWidth-1:0]   wstrb_q;
  logic [DataWidth-1:0]   rdata_q;
  logic                   err_q;
  logic                   setup;
  logic                   expire;
  logic                   valid;
  logic                   pready;

  // Setup phase is only honoured from IDLE; one seen in RESP is ignored.
  assign setup = psel_i & ~penable_i;

`ifdef APB4_TO_REG_TIMEOUT_EN
  localparam int unsigned CntWidth = $clog2(TimeoutCycles + 1);

  logic [CntWidth-1:0] cnt_q;

  // Counts completed unacknowledged REQ cycles; the access expires in the
  // REQ cycle that would make it reach TimeoutCycles, so valid is high for
  // exactly TimeoutCycles cycles.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (state_q == IDLE && setup) begin
      cnt_q <= '0;
    end else if (state_q == REQ && !reg_o.ready) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // Ready in the same cycle wins over expiry.
  assign expire = (state_q == REQ) && !reg_o.ready &&
                  (cnt_q == CntWidth'(TimeoutCycles - 1));
`else
  logic [31:0] unused_timeout;

  assign unused_timeout = TimeoutCycles;
  assign expire         = 1'b0;
`endif

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; psel dropping during REQ does not abandon the access.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (setup) state_d = REQ;
      REQ:     if (reg_o.ready || expire) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    valid  = 1'b0;
    pready = 1'b0;
    unique case (state_q)
      REQ:     valid  = 1'b1;
      RESP:    pready = 1'b1;
      default: ;
    endcase
  end

  // Request capture and response registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      addr_q  <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
      wstrb_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      if (state_q == IDLE && setup) begin
        addr_q  <= paddr_i;
        write_q <= pwrite_i;
        wdata_q <= pwdata_i;
        wstrb_q <= pwrite_i ? pstrb_i : '0;
      end
      if (state_q == REQ) begin
        if (reg_o.ready) begin
          rdata_q <= write_q ? '0 : reg_o.rdata;
          err_q   <= reg_o.error;
        end else if (expire) begin
          rdata_q <= '0;
          err_q   <= 1'b1;
        end
      end
    end
  end

  assign reg_o.addr  = addr_q;
  assign reg_o.write = write_q;
  assign reg_o.wdata = wdata_q;
  assign reg_o.wstrb = wstrb_q;
  assign reg_o.valid = valid;

  assign prdata_o  = rdata_q;
  assign pslverr_o = err_q;
  assign pready_o  = pready;

endmodule
